// File: rtl/uart_rx_mmio_if.sv
// Bus bundle between rx_uart/CPU and the uart_rx_mmio receive peripheral.
// master drives the receive strobe and read request; slave returns the read response.
interface uart_rx_mmio_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        rd_hit;

   modport master (
      output rx_valid, rx_data, rd_en, rd_addr,
      input  rd_data, rd_hit
   );

   modport slave (
      input  rx_valid, rx_data, rd_en, rd_addr,
      output rd_data, rd_hit
   );
endinterface

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receive FIFO: DATA at BASE_ADDR, STATUS at BASE_ADDR+4.
// Optional macro UART_RX_IRQ_EN adds a registered o_irq = (nonempty | overflow).
module uart_rx_mmio #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 i_reset,
`ifdef UART_RX_IRQ_EN
   output logic                 o_irq,
`endif
   uart_rx_mmio_if.slave        bus_io
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam int unsigned PtrW  = DEPTH_LOG2;
   localparam int unsigned CntW  = DEPTH_LOG2 + 1;

   logic [7:0]      mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [31:0]     rd_data_q, rd_data_d;
   logic            rd_hit_q, rd_hit_d;

   logic data_sel, stat_sel, full, nonempty, pop, push, ovf_evt;

   always_comb begin
      data_sel = bus_io.rd_en && (bus_io.rd_addr == BASE_ADDR);
      stat_sel = bus_io.rd_en && (bus_io.rd_addr == BASE_ADDR + 32'd4);
      full     = (count_q == CntW'(Depth));
      nonempty = (count_q != '0);
      pop      = data_sel && nonempty;
      // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
      push     = bus_io.rx_valid && (!full || pop);
      ovf_evt  = bus_io.rx_valid && full && !pop;

      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      overflow_d = overflow_q;
      if (stat_sel) overflow_d = 1'b0;
      if (ovf_evt)  overflow_d = 1'b1;

      rd_hit_d  = data_sel || stat_sel;
      rd_data_d = '0;
      if (data_sel) begin
         rd_data_d = {24'b0, nonempty ? mem_q[rd_ptr_q] : 8'h00};
      end else if (stat_sel) begin
         rd_data_d = {16'b0, 8'(count_q), 5'b0, overflow_q, full, nonempty};
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_data_q  <= '0;
         rd_hit_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
         rd_hit_q   <= rd_hit_d;
      end
   end

   // Storage is not reset; only the pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (!i_reset && push) begin
         mem_q[wr_ptr_q] <= bus_io.rx_data;
      end
   end

   assign bus_io.rd_data = rd_data_q;
   assign bus_io.rd_hit  = rd_hit_q;

`ifdef UART_RX_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (count_d != '0) || overflow_d;
      end
   end

   assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: queue-based model checked every cycle plus literal read checks.
// Also exercises o_irq when compiled with UART_RX_IRQ_EN.
module tb_uart_rx_mmio;

   localparam logic [31:0] Base  = 32'h0000_F000;
   localparam int unsigned Depth = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq;

   uart_rx_mmio_if bus ();

   uart_rx_mmio #(
      .BASE_ADDR  (Base),
      .DEPTH_LOG2 (4)
   ) dut (
      .clk     (clk),
      .i_reset (rst),
`ifdef UART_RX_IRQ_EN
      .o_irq   (irq),
`endif
      .bus_io  (bus)
   );

`ifndef UART_RX_IRQ_EN
   assign irq = 1'b0;
`endif

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a byte queue and a sticky overflow flag, advanced once per clock edge.
   logic [7:0]  mq[$];
   logic        m_ovf = 1'b0;
   logic        exp_hit;
   logic [31:0] exp_data;
   logic        exp_irq;

   always begin
      logic is_data, is_stat;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_ovf    = 1'b0;
         exp_hit  = 1'b0;
         exp_data = '0;
         exp_irq  = 1'b0;
      end else begin
         is_data  = bus.rd_en && (bus.rd_addr == Base);
         is_stat  = bus.rd_en && (bus.rd_addr == Base + 32'd4);
         exp_hit  = is_data || is_stat;
         exp_data = '0;
         if (is_stat) begin
            exp_data = {16'b0, 8'(mq.size()), 5'b0, m_ovf,
                        mq.size() == Depth, mq.size() != 0};
            m_ovf = 1'b0;
         end
         if (is_data && mq.size() > 0) begin
            exp_data = {24'b0, mq.pop_front()};
         end
         if (bus.rx_valid) begin
            if (mq.size() < Depth) mq.push_back(bus.rx_data);
            else m_ovf = 1'b1;
         end
         exp_irq = (mq.size() != 0) || m_ovf;
      end
      #1;
      check("model rd_hit", {31'b0, bus.rd_hit}, {31'b0, exp_hit});
      check("model rd_data", bus.rd_data, exp_data);
`ifdef UART_RX_IRQ_EN
      check("model o_irq", {31'b0, irq}, {31'b0, exp_irq});
`endif
   end

   task automatic push(input logic [7:0] b);
      @(posedge clk);
      #2 bus.rx_valid = 1'b1;
      bus.rx_data = b;
      @(posedge clk);
      #2 bus.rx_valid = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [31:0] addr,
                             input logic hit, input logic [31:0] exp);
      @(posedge clk);
      #2 bus.rd_en = 1'b1;
      bus.rd_addr = addr;
      @(posedge clk);
      #2 bus.rd_en = 1'b0;
      bus.rd_addr = '0;
      check({name, " hit"}, {31'b0, bus.rd_hit}, {31'b0, hit});
      check(name, bus.rd_data, exp);
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      bus.rd_en    = 1'b0;
      bus.rd_addr  = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      check("reset rd_hit", {31'b0, bus.rd_hit}, 32'd0);
      check("reset rd_data", bus.rd_data, 32'd0);
      read_check("status after reset", Base + 4, 1'b1, 32'h0000_0000);

      // Two bytes in, two out.
      push(8'h41);
`ifdef UART_RX_IRQ_EN
      check("irq after first push", {31'b0, irq}, 32'd1);
`endif
      push(8'h42);
      read_check("status two bytes", Base + 4, 1'b1, 32'h0000_0201);
      read_check("data 0x41", Base, 1'b1, 32'h0000_0041);
      read_check("data 0x42", Base, 1'b1, 32'h0000_0042);
`ifdef UART_RX_IRQ_EN
      check("irq after last pop", {31'b0, irq}, 32'd0);
`endif
      read_check("status drained", Base + 4, 1'b1, 32'h0000_0000);

      // Overflow: 17 bytes into a 16-deep FIFO.
      for (int i = 0; i < 17; i++) push(8'(i));
      read_check("status overflow", Base + 4, 1'b1, 32'h0000_1007);
      read_check("status ovf cleared", Base + 4, 1'b1, 32'h0000_1003);
      for (int i = 0; i < 16; i++) read_check("overflow drain", Base, 1'b1, 32'(i));
      read_check("status after drain", Base + 4, 1'b1, 32'h0000_0000);

      // Pointer wrap past index 15.
      for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
      for (int i = 0; i < 10; i++) read_check("wrap pop a", Base, 1'b1, 32'h20 + 32'(i));
      for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
      for (int i = 0; i < 10; i++) read_check("wrap pop b", Base, 1'b1, 32'h30 + 32'(i));

      // Full FIFO: push and pop in the same cycle.
      for (int i = 0; i < 16; i++) push(8'h50 + 8'(i));
      @(posedge clk);
      #2 bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hAA;
      bus.rd_en    = 1'b1;
      bus.rd_addr  = Base;
      @(posedge clk);
      #2 bus.rx_valid = 1'b0;
      bus.rd_en    = 1'b0;
      check("full push+pop data", bus.rd_data, 32'h0000_0050);
      read_check("full push+pop status", Base + 4, 1'b1, 32'h0000_1003);
      for (int i = 1; i < 16; i++) read_check("full drain", Base, 1'b1, 32'h50 + 32'(i));
      read_check("0xAA last", Base, 1'b1, 32'h0000_00AA);

      // Empty read, unmapped address, and empty read racing a push.
      read_check("empty data read", Base, 1'b1, 32'h0000_0000);
      read_check("unmapped read", Base + 8, 1'b0, 32'h0000_0000);
      @(posedge clk);
      #2 bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h77;
      bus.rd_en    = 1'b1;
      bus.rd_addr  = Base;
      @(posedge clk);
      #2 bus.rx_valid = 1'b0;
      bus.rd_en    = 1'b0;
      check("empty read+push data", bus.rd_data, 32'h0000_0000);
      read_check("empty read+push status", Base + 4, 1'b1, 32'h0000_0101);

      // Reset mid-operation discards contents and ignores same-cycle traffic.
      push(8'h11);
      @(posedge clk);
      #2 rst = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h33;
      bus.rd_en    = 1'b1;
      bus.rd_addr  = Base + 4;
      @(posedge clk);
      #2 rst = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rd_en    = 1'b0;
      check("reset mid-op rd_hit", {31'b0, bus.rd_hit}, 32'd0);
      read_check("status after mid-op reset", Base + 4, 1'b1, 32'h0000_0000);

      repeat (3) @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped UART receive peripheral: the CPU-read counterpart of the existing write-side uart transmitter.
- Buffers bytes from rx_uart (rx_valid/rx_data) in a FIFO and returns them to the cpu through its read port (rd_addr/rd_data).
- Sits beside ram on the cpu read bus. Its rd_data is zero when not addressed, so the top level ORs it with the ram read data.

Parameters:
- BASE_ADDR, 32'h0000_F000, byte address of the DATA register; STATUS is at BASE_ADDR+4.
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 1..7.

Ports:
- clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle strobe from rx_uart, byte present on rx_data
- rx_data  input  8  received byte, valid only when rx_valid=1
- rd_en  input  1  cpu read strobe, one cycle per access
- rd_addr  input  32  cpu read byte address
- rd_data  output  32  read result, registered; 0 when not addressed
- rd_hit  output  1  registered; 1 in the cycle rd_data carries this block's response
- o_irq  output  1  present only with UART_RX_IRQ_EN (see Optional Feature)

Behaviour:
- Reset (i_reset=1 at a clk edge):
  - Outputs: rd_data=0, rd_hit=0, o_irq=0.
  - Internal state: wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Reset mid-operation discards all FIFO contents. A read or rx_valid in the reset cycle is ignored.
- FIFO:
  - DEPTH=2^DEPTH_LOG2 entries, 8 bits each.
  - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
  - count is DEPTH_LOG2+1 bits, range 0..DEPTH.
- Push: rx_valid=1 and (count<DEPTH or pop this cycle) -> write rx_data at wr_ptr, then wr_ptr+1.
- Overflow: rx_valid=1, count==DEPTH and no pop this cycle -> byte dropped, overflow set sticky.
- Address decode:
  - data_sel = rd_en and rd_addr==BASE_ADDR.
  - stat_sel = rd_en and rd_addr==BASE_ADDR+4.
  - Any other address -> no effect. Next cycle rd_data=0, rd_hit=0.
- DATA read (data_sel):
  - Latency 1: the next cycle gives rd_hit=1 and rd_data={24'b0, mem[rd_ptr]}.
  - If count>0, pop: rd_ptr+1, count-1.
  - If count==0: rd_data=0, no pointer change, no error flag.
- STATUS read (stat_sel):
  - Next cycle rd_hit=1, rd_data holds:
    - [0] nonempty = count!=0
    - [1] full = count==DEPTH
    - [2] overflow
    - [15:8] count, zero-extended
    - all other bits 0.
  - Values are sampled in the cycle of the read, before that cycle's push takes effect.
  - overflow clears on a STATUS read. If a new overflow event occurs in the same cycle, overflow stays 1.
- Simultaneous events:
  - Push+pop with 0<count<DEPTH: both occur, count unchanged.
  - Push+pop at count==DEPTH: pop frees a slot, push accepted, count stays DEPTH, no overflow.
  - Push with a DATA read at count==0: the read returns 0, the byte is stored, count becomes 1.
- rd_data/rd_hit hold their values for one cycle only. Without a hit they return to 0 on the next edge.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro UART_RX_IRQ_EN.
- Defined:
  - Port o_irq exists.
  - o_irq is registered and equals (count!=0 or overflow), updated each cycle from the next-state values.
  - o_irq deasserts the cycle after the last byte is popped, provided overflow=0.
  - Reset value 0.
- Undefined: port o_irq and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then STATUS read -> next cycle rd_hit=1, rd_data=32'h0000_0000.
- Push 0x41, 0x42 (rx_valid pulses) -> STATUS reads 32'h0000_0201; DATA, DATA returns 0x41 then 0x42; then STATUS reads 32'h0000_0000.
- DEPTH_LOG2=4: push 17 bytes 0x00..0x10.
  - STATUS -> 32'h0000_1007 (count 16, full, overflow, nonempty).
  - Second STATUS -> 32'h0000_1003.
  - 16 DATA reads -> 0x00..0x0F in order, 0x10 lost.
- Wrap-around: push 10 bytes, pop 10, push 10 more, pop all -> correct order, pointers cross index 15->0.
- At count==16, rx_valid=0xAA in the same cycle as a DATA read -> read returns the oldest byte, no overflow set, count stays 16, 0xAA read last.
- DATA read when empty -> rd_data=0, rd_hit=1. Read of BASE_ADDR+8 -> rd_hit=0, rd_data=0. With UART_RX_IRQ_EN: o_irq=1 one cycle after the first push, 0 one cycle after the final pop.
